// File: rtl/imem_responder.sv
// Instruction memory responder: preloadable word store answering fetch requests in order.
// Latency: response valid exactly LATENCY cycles after acceptance when rsp_ready is held high.
// Backpressure: req_ready drops once LATENCY+1 requests are outstanding; an output FIFO holds completed reads.
module imem_responder #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_err,
  input  logic                     load_en,
  input  logic [ADDRESS_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]    load_data
);

  localparam int WORDS = 1 << (ADDRESS_WIDTH - 2);
  localparam int DEPTH = LATENCY + 1;
  localparam int CW    = $clog2(LATENCY + 2);
  localparam int PW    = $clog2(DEPTH);
  localparam int FW    = $clog2(DEPTH + 1);
  localparam int EW    = DATA_WIDTH + 1;  // {err, data}

  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          acc, dlv, misaligned;
  logic [EW-1:0] acc_ent;

  logic          wr_vld;
  logic [EW-1:0] wr_ent;

  logic [EW-1:0] fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fifo_cnt_q, fifo_cnt_d;

  // Low byte-offset bits of the preload address carry no information for word storage.
  logic load_lo_unused;
  assign load_lo_unused = ^load_addr[1:0];

  // Flow control is based only on the registered outstanding count.
  assign req_ready  = out_cnt_q < CW'(LATENCY + 1);
  assign acc        = req_valid & req_ready;
  assign dlv        = rsp_valid & rsp_ready;
  assign misaligned = req_addr[1:0] != 2'b00;
  // Memory is read at the acceptance edge, so a same-edge load is not yet visible (old value returned).
  assign acc_ent    = misaligned ? {1'b1, {DATA_WIDTH{1'b0}}}
                                 : {1'b0, mem_q[req_addr[ADDRESS_WIDTH-1:2]]};

  // Preload writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (load_en) mem_q[load_addr[ADDRESS_WIDTH-1:2]] <= load_data;
  end

  // Next outstanding count: +1 on accept, -1 on deliver, unchanged when both.
  always_comb begin
    out_cnt_d = out_cnt_q;
    case ({acc, dlv})
      2'b10:   out_cnt_d = out_cnt_q + CW'(1);
      2'b01:   out_cnt_d = out_cnt_q - CW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // Outstanding counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_cnt_q <= '0;
    else      out_cnt_q <= out_cnt_d;
  end

  // Fixed-delay read pipeline: the acceptance edge is the first stage, the FIFO write the last.
  if (LATENCY == 1) begin : g_direct
    assign wr_vld = acc;
    assign wr_ent = acc_ent;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld_q;
    logic [EW-1:0]      ent_q [LATENCY-1];

    // Shift one stage per cycle without stalling; the output FIFO absorbs backpressure.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q <= '0;
        for (int i = 0; i < LATENCY - 1; i++) ent_q[i] <= '0;
      end else begin
        vld_q[0] <= acc;
        ent_q[0] <= acc_ent;
        for (int i = 1; i < LATENCY - 1; i++) begin
          vld_q[i] <= vld_q[i-1];
          ent_q[i] <= ent_q[i-1];
        end
      end
    end

    assign wr_vld = vld_q[LATENCY-2];
    assign wr_ent = ent_q[LATENCY-2];
  end

  // FIFO pointer and occupancy next-state; depth LATENCY+1 equals the outstanding cap, so no overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (wr_vld) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (dlv)    rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    case ({wr_vld, dlv})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - FW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // FIFO control registers; clearing them discards every in-flight response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // FIFO storage; entries are only observed through a valid read pointer.
  always_ff @(posedge clk) begin
    if (wr_vld) fifo_q[wr_ptr_q] <= wr_ent;
  end

  // Outputs are forced to zero whenever no response is presented.
  assign rsp_valid = fifo_cnt_q != '0;
  assign rsp_data  = rsp_valid ? fifo_q[rd_ptr_q][DATA_WIDTH-1:0] : '0;
  assign rsp_err   = rsp_valid & fifo_q[rd_ptr_q][DATA_WIDTH];

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with LATENCY=2, ADDRESS_WIDTH=5, DATA_WIDTH=32.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_imem_responder;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [4:0]  req_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [31:0] load_data;

  int checks = 0;
  int errors = 0;

  imem_responder #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [4:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h err=%b, want 0/0/0", rsp_valid, rsp_data, rsp_err);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b, want 1", req_ready);
    end
  endtask

  task automatic test_basic();
    load_word(5'h04, 32'h00500093);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 5'h04;
    tick();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: rsp_valid=%b one cycle after accept, want 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h00500093 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_rsp: valid=%b data=%h err=%b, want 1/00500093/0", rsp_valid, rsp_data, rsp_err);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle_zero: valid=%b data=%h err=%b, want 0/0/0", rsp_valid, rsp_data, rsp_err);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_w [4];
    exp_w = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int w = 0; w < 4; w++) load_word(5'(w * 4), exp_w[w]);
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_valid = (i < 4);
      req_addr  = 5'((i % 4) * 4);
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready[%0d]: req_ready=%b, want 1", i, req_ready);
      end
      tick();
      if (i >= 1 && i <= 4) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_w[i-1] || rsp_err !== 1'b0) begin
          errors++;
          $display("FAIL stream_rsp[%0d]: valid=%b data=%h err=%b, want 1/%h/0",
                   i - 1, rsp_valid, rsp_data, rsp_err, exp_w[i-1]);
        end
      end
    end
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: rsp_valid=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    int acc_cnt;
    logic [31:0] exp_w [3];
    exp_w = '{32'h11, 32'h22, 32'h33};
    acc_cnt = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_addr  = 5'(acc_cnt * 4);
      if (req_ready === 1'b1) acc_cnt++;
      tick();
    end
    req_valid = 1'b0;
    checks++;
    if (acc_cnt !== 3) begin
      errors++;
      $display("FAIL bp_accepted: accepted=%0d, want 3", acc_cnt);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_low: req_ready=%b, want 0", req_ready);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h11 || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h err=%b, want 1/00000011/0", i, rsp_valid, rsp_data, rsp_err);
      end
      tick();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_w[i]) begin
        errors++;
        $display("FAIL bp_drain[%0d]: valid=%b data=%h, want 1/%h", i, rsp_valid, rsp_data, exp_w[i]);
      end
      tick();
    end
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_end: rsp_valid=%b req_ready=%b, want 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_misaligned();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 5'h06;
    tick();
    req_addr = 5'h08;
    tick();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL misaligned_rsp: valid=%b err=%b data=%h, want 1/1/0", rsp_valid, rsp_err, rsp_data);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h33) begin
      errors++;
      $display("FAIL misaligned_next: valid=%b err=%b data=%h, want 1/0/00000033", rsp_valid, rsp_err, rsp_data);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    int seen;
    load_word(5'h04, 32'h00500093);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 5'h00;
    tick();
    req_addr = 5'h04;
    tick();
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: valid=%b data=%h err=%b, want 0/0/0", rsp_valid, rsp_data, rsp_err);
    end
    tick();
    rst = 1'b1;
    rsp_ready = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready: req_ready=%b, want 1", req_ready);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midrst_stale: stale response cycles=%0d, want 0", seen);
    end
    req_valid = 1'b1; req_addr = 5'h04;
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h00500093) begin
      errors++;
      $display("FAIL midrst_reread: valid=%b data=%h, want 1/00500093", rsp_valid, rsp_data);
    end
    tick();
  endtask

  task automatic test_load_collision();
    rsp_ready = 1'b1;
    load_en = 1'b1; load_addr = 5'h08; load_data = 32'hDEADBEEF;
    req_valid = 1'b1; req_addr = 5'h08;
    tick();
    load_en = 1'b0;
    req_valid = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h33) begin
      errors++;
      $display("FAIL collide_old: valid=%b data=%h, want 1/00000033", rsp_valid, rsp_data);
    end
    req_valid = 1'b1; req_addr = 5'h08;
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL collide_new: valid=%b data=%h, want 1/deadbeef", rsp_valid, rsp_data);
    end
    tick();
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    #1;
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_misaligned();
    test_reset_midflight();
    test_load_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 5, byte-address width of fetch requests.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 The block SHALL have parameter LATENCY, default 2, request-to-response cycles (legal range 1..4).
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-006 The block SHALL have port req_valid  input  1  fetch request present.
REQ-007 The block SHALL have port req_ready  output  1  request may be accepted this cycle.
REQ-008 The block SHALL have port req_addr  input  ADDRESS_WIDTH  byte address (PC) of requested instruction.
REQ-009 The block SHALL have port rsp_valid  output  1  response present.
REQ-010 The block SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-011 The block SHALL have port rsp_data  output  DATA_WIDTH  instruction word.
REQ-012 The block SHALL have port rsp_err  output  1  response is for a misaligned address.
REQ-013 The block SHALL have port load_en  input  1  preload write strobe.
REQ-014 The block SHALL have port load_addr  input  ADDRESS_WIDTH  preload byte address; bits [1:0] ignored.
REQ-015 The block SHALL have port load_data  input  DATA_WIDTH  preload word.

Function
REQ-016 Storage SHALL be 2^(ADDRESS_WIDTH-2) words indexed by address bits [ADDRESS_WIDTH-1:2].
REQ-017 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; a response SHALL be delivered on an edge where rsp_valid=1 and rsp_ready=1.
REQ-018 The memory word SHALL be sampled at the acceptance edge; with rsp_ready held 1, the response SHALL appear with rsp_valid=1 exactly LATENCY cycles after acceptance.
REQ-019 Responses SHALL be delivered in acceptance order, with no drops or duplicates.
REQ-020 An outstanding counter SHALL count accepted but undelivered requests (range 0..LATENCY+1), incrementing on acceptance and decrementing on delivery; both in one cycle leaves it unchanged.
REQ-021 req_ready SHALL be 1 iff outstanding < LATENCY+1, registered-count based, with no combinational path from rsp_ready or req_valid.
REQ-022 Completed reads SHALL be held in an output FIFO of depth LATENCY+1 that never overflows; with rsp_ready=1 continuously, throughput SHALL be one response per cycle.
REQ-023 While rsp_valid=1 and rsp_ready=0, rsp_data and rsp_err SHALL hold stable.
REQ-024 If req_addr[1:0] != 0, the response SHALL carry rsp_err=1 and rsp_data=0, with the same latency and ordering as a normal response.
REQ-025 When load_en=1, load_data SHALL be written at the rising edge; load SHALL be legal while requests are outstanding.
REQ-026 A request accepted in the same cycle as a load to the same word SHALL return the old value.
REQ-027 When rsp_valid=0, rsp_data and rsp_err SHALL be 0.

Reset
REQ-028 With rst=0, the block SHALL immediately drive rsp_valid=0, rsp_err=0 and rsp_data=0, and SHALL clear the outstanding count, pipeline and FIFO.
REQ-029 req_ready SHALL be 1 on the first cycle after rst returns to 1.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight requests; no stale response SHALL appear after release.
REQ-031 Memory contents SHALL NOT be reset and SHALL survive reset.

Verification (LATENCY=2)
REQ-032 Basic read: preload word1=0x00500093, then req_addr=0x04 accepted at cycle 0 with rsp_ready=1 -> rsp_valid=1, rsp_data=0x00500093, rsp_err=0 at cycle 2.
REQ-033 Streaming: preload words 0..3 with 0x11,0x22,0x33,0x44; requests 0x00,0x04,0x08,0x0C on cycles 0-3 -> responses 0x11..0x44 on cycles 2-5, and req_ready stays 1 throughout.
REQ-034 Backpressure: rsp_ready=0 and 5 requests offered -> exactly 3 accepted, then req_ready=0 and rsp_data held stable; raising rsp_ready -> 3 in-order responses, then req_ready=1.
REQ-035 Misaligned: req_addr=0x06 -> at cycle 2, rsp_err=1 and rsp_data=0; a following request to 0x08 returns the normal word.
REQ-036 Reset mid-flight: 2 requests outstanding, rst=0 for 1 cycle -> rsp_valid=0 at once, req_ready=1 after release, no response for either request; a re-read of word1 still returns 0x00500093.
REQ-037 Load collision: load word2=0xDEADBEEF in the same cycle as accepting req 0x08 (old value 0x33) -> response 0x33; the next request to 0x08 -> 0xDEADBEEF.
